// File: rtl/tlb_maint_ctrl.sv
// tlb_maint_ctrl
//   Sequencer for TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR,
//   TLBFILL, INVTLB). Takes one request at a time from the CSR/EXE stage
//   over a valid/ready handshake and drives the TLB array's search, read
//   and write ports. INVTLB walks every entry, one per cycle, clearing
//   the valid (e) bit of each matching entry. It also keeps the
//   round-robin fill pointer used by TLBFILL.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   req_*             request channel (valid/ready, op, inv_op, asid,
//                     vppn, index, entry)
//   resp_*            completion pulse plus found/index/entry/err results
//   tlb_s_*           TLB search port (vppn/asid out, found/index in)
//   tlb_r_*           TLB read port (index out, combinational entry in)
//   tlb_we, tlb_w_*   TLB write port
//
// Entry packing (msb->lsb, 89 bits):
//   e, vppn[19], ps[6], asid[10], g, ppn0[20], plv0[2], mat0[2], d0, v0,
//   ppn1[20], plv1[2], mat1[2], d1, v1
module tlb_maint_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_inv_op,
  input  logic [9:0]      req_asid,
  input  logic [18:0]     req_vppn,
  input  logic [IDXW-1:0] req_index,
  input  logic [88:0]     req_entry,
  output logic            resp_valid,
  output logic            resp_found,
  output logic [IDXW-1:0] resp_index,
  output logic [88:0]     resp_entry,
  output logic            resp_err,
  output logic [18:0]     tlb_s_vppn,
  output logic [9:0]      tlb_s_asid,
  input  logic            tlb_s_found,
  input  logic [IDXW-1:0] tlb_s_index,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic [88:0]     tlb_r_entry,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic [88:0]     tlb_w_entry
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] fill_ptr_q, fill_ptr_d;
  logic [IDXW-1:0] scan_idx_q, scan_idx_d;
  logic            resp_found_q, resp_found_d;
  logic [IDXW-1:0] resp_index_q, resp_index_d;
  logic [88:0]     resp_entry_q, resp_entry_d;
  logic            resp_err_q, resp_err_d;

  // Latched request fields (datapath only, no reset needed)
  logic [2:0]      op_q, op_d;
  logic [4:0]      inv_op_q, inv_op_d;
  logic [9:0]      asid_q, asid_d;
  logic [18:0]     vppn_q, vppn_d;
  logic [IDXW-1:0] index_q, index_d;
  logic [88:0]     entry_q, entry_d;

  logic accept;
  logic scan_hit;

  // INVTLB selection for one entry. A 4MB page (ps==22) only compares
  // the upper VPPN bits, the rest compare the whole VPPN.
  function automatic logic inv_match(input logic [4:0]  iop,
                                     input logic [88:0] ent,
                                     input logic [9:0]  asid,
                                     input logic [18:0] vppn);
    logic g, asid_eq, vm;
    g       = ent[52];
    asid_eq = (ent[62:53] == asid);
    if (ent[68:63] == 6'd22) vm = (ent[87:79] == vppn[18:10]);
    else                     vm = (ent[87:69] == vppn);
    case (iop)
      5'd0, 5'd1: inv_match = 1'b1;
      5'd2:       inv_match = g;
      5'd3:       inv_match = !g;
      5'd4:       inv_match = !g && asid_eq;
      5'd5:       inv_match = !g && asid_eq && vm;
      5'd6:       inv_match = (g || asid_eq) && vm;
      default:    inv_match = 1'b0;
    endcase
  endfunction

  assign accept      = req_valid && (state_q == IDLE);
  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_found  = resp_found_q;
  assign resp_index  = resp_index_q;
  assign resp_entry  = resp_entry_q;
  assign resp_err    = resp_err_q;
  assign tlb_s_vppn  = vppn_q;
  assign tlb_s_asid  = asid_q;
  assign tlb_r_index = (state_q == SCAN) ? scan_idx_q : index_q;
  assign scan_hit    = inv_match(inv_op_q, tlb_r_entry, asid_q, vppn_q) && tlb_r_entry[88];

  always_comb begin
    op_d     = op_q;
    inv_op_d = inv_op_q;
    asid_d   = asid_q;
    vppn_d   = vppn_q;
    index_d  = index_q;
    entry_d  = entry_q;
    if (accept) begin
      op_d     = req_op;
      inv_op_d = req_inv_op;
      asid_d   = req_asid;
      vppn_d   = req_vppn;
      index_d  = req_index;
      entry_d  = req_entry;
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_ptr_d   = fill_ptr_q;
    scan_idx_d   = scan_idx_q;
    resp_found_d = resp_found_q;
    resp_index_d = resp_index_q;
    resp_entry_d = resp_entry_q;
    resp_err_d   = resp_err_q;
    tlb_we       = 1'b0;
    tlb_w_index  = '0;
    tlb_w_entry  = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_op == OP_INV && req_inv_op <= 5'd6) state_d = SCAN;
          else                                        state_d = EXEC;
        end
      end

      // Single TLB access; results are captured on the way to DONE.
      // An INV reaching EXEC always carries an illegal inv_op.
      EXEC: begin
        resp_found_d = 1'b0;
        resp_index_d = '0;
        resp_entry_d = '0;
        resp_err_d   = 1'b0;
        case (op_q)
          OP_SRCH: begin
            resp_found_d = tlb_s_found;
            resp_index_d = tlb_s_found ? tlb_s_index : '0;
          end
          OP_RD: resp_entry_d = tlb_r_entry;
          OP_WR: begin
            tlb_we      = 1'b1;
            tlb_w_index = index_q;
            tlb_w_entry = entry_q;
          end
          OP_FILL: begin
            tlb_we       = 1'b1;
            tlb_w_index  = fill_ptr_q;
            tlb_w_entry  = entry_q;
            resp_index_d = fill_ptr_q;
            fill_ptr_d   = fill_ptr_q + IDXW'(1);
          end
          default: resp_err_d = 1'b1;
        endcase
        state_d = DONE;
      end

      // One entry per cycle; a matching valid entry is rewritten in the
      // same cycle with only its e bit cleared.
      SCAN: begin
        if (scan_hit) begin
          tlb_we      = 1'b1;
          tlb_w_index = scan_idx_q;
          tlb_w_entry = {1'b0, tlb_r_entry[87:0]};
        end
        if (scan_idx_q == IDXW'(TLBNUM - 1)) begin
          scan_idx_d   = '0;
          resp_found_d = 1'b0;
          resp_index_d = '0;
          resp_entry_d = '0;
          resp_err_d   = 1'b0;
          state_d      = DONE;
        end else begin
          scan_idx_d = scan_idx_q + IDXW'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fill_ptr_q   <= '0;
      scan_idx_q   <= '0;
      resp_found_q <= 1'b0;
      resp_index_q <= '0;
      resp_entry_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_ptr_q   <= fill_ptr_d;
      scan_idx_q   <= scan_idx_d;
      resp_found_q <= resp_found_d;
      resp_index_q <= resp_index_d;
      resp_entry_q <= resp_entry_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q     <= op_d;
    inv_op_q <= inv_op_d;
    asid_q   <= asid_d;
    vppn_q   <= vppn_d;
    index_q  <= index_d;
    entry_q  <= entry_d;
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Testbench for tlb_maint_ctrl: a behavioural 16-entry TLB array sits on
// the DUT's search/read/write ports, and directed requests are issued in
// sequence with hand-computed expected results.
module tb_tlb_maint_ctrl;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [4:0]      req_inv_op;
  logic [9:0]      req_asid;
  logic [18:0]     req_vppn;
  logic [IDXW-1:0] req_index;
  logic [88:0]     req_entry;
  logic            resp_valid;
  logic            resp_found;
  logic [IDXW-1:0] resp_index;
  logic [88:0]     resp_entry;
  logic            resp_err;
  logic [18:0]     tlb_s_vppn;
  logic [9:0]      tlb_s_asid;
  logic            tlb_s_found;
  logic [IDXW-1:0] tlb_s_index;
  logic [IDXW-1:0] tlb_r_index;
  logic [88:0]     tlb_r_entry;
  logic            tlb_we;
  logic [IDXW-1:0] tlb_w_index;
  logic [88:0]     tlb_w_entry;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tlb_maint_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inv_op(req_inv_op), .req_asid(req_asid), .req_vppn(req_vppn),
    .req_index(req_index), .req_entry(req_entry),
    .resp_valid(resp_valid), .resp_found(resp_found), .resp_index(resp_index),
    .resp_entry(resp_entry), .resp_err(resp_err),
    .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
    .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry)
  );

  // Behavioural TLB array; the bench preloads it through bk_* so that
  // every write happens in this one process.
  logic [88:0]     mem [TLBNUM];
  logic            bk_we, bk_clr;
  logic [IDXW-1:0] bk_idx;
  logic [88:0]     bk_data;

  always @(posedge clk) begin
    if (bk_clr) begin
      for (int i = 0; i < TLBNUM; i++) mem[i] <= '0;
    end else if (bk_we) begin
      mem[bk_idx] <= bk_data;
    end
    if (tlb_we) mem[tlb_w_index] <= tlb_w_entry;
  end

  assign tlb_r_entry = mem[tlb_r_index];

  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      if (mem[i][88] && (mem[i][52] || mem[i][62:53] == tlb_s_asid) &&
          ((mem[i][68:63] == 6'd22) ? (mem[i][87:79] == tlb_s_vppn[18:10])
                                    : (mem[i][87:69] == tlb_s_vppn))) begin
        tlb_s_found = 1'b1;
        tlb_s_index = IDXW'(i);
      end
    end
  end

  function automatic logic [88:0] mk_ent(input logic e, input logic [18:0] vppn,
                                         input logic [5:0] ps, input logic [9:0] asid,
                                         input logic g, input logic [19:0] ppn0);
    return {e, vppn, ps, asid, g, ppn0, 2'd0, 2'd0, 1'b0, 1'b1,
            20'h0, 2'd0, 2'd0, 1'b0, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [88:0] obs, input logic [88:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [IDXW-1:0] idx, input logic [88:0] data);
    bk_idx = idx; bk_data = data; bk_we = 1'b1;
    @(posedge clk); #1;
    bk_we = 1'b0;
  endtask

  task automatic clear_mem();
    bk_clr = 1'b1;
    @(posedge clk); #1;
    bk_clr = 1'b0;
  endtask

  // Issues one request and follows it to resp_valid. lat is the number of
  // edges from the accept edge to the DONE cycle; wes counts write pulses.
  task automatic do_req(input logic [2:0] op, input logic [4:0] iop,
                        input logic [9:0] asid, input logic [18:0] vppn,
                        input logic [IDXW-1:0] idx, input logic [88:0] ent,
                        output int lat, output int wes, output logic [IDXW-1:0] widx);
    int guard;
    guard = 0;
    while (!req_ready && guard < 5) begin
      @(posedge clk); #1; guard++;
    end
    req_op = op; req_inv_op = iop; req_asid = asid; req_vppn = vppn;
    req_index = idx; req_entry = ent; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; wes = 0; widx = '0;
    while (!resp_valid && lat < 40) begin
      if (tlb_we) begin wes++; widx = tlb_w_index; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int              lat, wes, cnt;
  logic [IDXW-1:0] widx;
  logic [88:0]     e5, e7;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_inv_op = '0;
    req_asid = '0; req_vppn = '0; req_index = '0; req_entry = '0;
    bk_we = 1'b0; bk_clr = 1'b1; bk_idx = '0; bk_data = '0;
    repeat (3) @(posedge clk);
    #1;
    bk_clr = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_found", resp_found, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_index", resp_index, 0);
    chk("rst_entry", resp_entry, 0);
    chk("rst_we", tlb_we, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", req_ready, 1);

    // Fill pointer: 0,1,...,15 then wraps to 0
    for (int i = 0; i < 17; i++) begin
      do_req(3'd3, 5'd0, 10'd0, 19'd0, 4'd0, mk_ent(1'b0, 19'(i), 6'd12, 10'd0, 1'b0, 20'(i)),
             lat, wes, widx);
      if (i < 4 || i >= 15) begin
        chk($sformatf("fill%0d_lat", i), lat, 2);
        chk($sformatf("fill%0d_idx", i), resp_index, 89'(i % 16));
        chk($sformatf("fill%0d_widx", i), widx, 89'(i % 16));
        chk($sformatf("fill%0d_wes", i), wes, 1);
      end
    end

    // WR then RD of entry 5
    clear_mem();
    e5 = mk_ent(1'b1, 19'h12345, 6'd12, 10'h3, 1'b0, 20'hABCDE);
    do_req(3'd2, 5'd0, 10'd0, 19'd0, 4'd5, e5, lat, wes, widx);
    chk("wr_lat", lat, 2);
    chk("wr_wes", wes, 1);
    chk("wr_widx", widx, 5);
    chk("wr_mem5", mem[5], e5);
    do_req(3'd1, 5'd0, 10'd0, 19'd0, 4'd5, '0, lat, wes, widx);
    chk("rd_lat", lat, 2);
    chk("rd_entry", resp_entry, e5);
    chk("rd_wes", wes, 0);

    // Searches against entry 5
    do_req(3'd0, 5'd0, 10'h3, 19'h12345, 4'd0, '0, lat, wes, widx);
    chk("srch_hit_found", resp_found, 1);
    chk("srch_hit_index", resp_index, 5);
    do_req(3'd0, 5'd0, 10'h4, 19'h12345, 4'd0, '0, lat, wes, widx);
    chk("srch_miss_found", resp_found, 0);

    // INV op 4 asid 3: only entry 7 is cleared
    clear_mem();
    e7 = mk_ent(1'b1, 19'h02000, 6'd12, 10'h3, 1'b0, 20'h2);
    preload(4'd2, mk_ent(1'b1, 19'h01000, 6'd12, 10'h3, 1'b1, 20'h1));
    preload(4'd7, e7);
    preload(4'd9, mk_ent(1'b1, 19'h03000, 6'd12, 10'h4, 1'b0, 20'h3));
    do_req(3'd4, 5'd4, 10'h3, 19'h0, 4'd0, '0, lat, wes, widx);
    chk("inv4_lat", lat, 17);
    chk("inv4_wes", wes, 1);
    chk("inv4_widx", widx, 7);
    chk("inv4_e7", mem[7][88], 0);
    chk("inv4_rest7", mem[7][87:0], e7[87:0]);
    chk("inv4_e2", mem[2][88], 1);
    chk("inv4_e9", mem[9][88], 1);
    chk("inv4_err", resp_err, 0);

    // INV op 6 with a 4MB page: only upper VPPN bits compared
    clear_mem();
    preload(4'd3, mk_ent(1'b1, 19'h12C00, 6'd22, 10'h5, 1'b0, 20'h4));
    preload(4'd4, mk_ent(1'b1, 19'h12C00, 6'd12, 10'h5, 1'b0, 20'h5));
    do_req(3'd4, 5'd6, 10'h5, 19'h12DFF, 4'd0, '0, lat, wes, widx);
    chk("inv6_lat", lat, 17);
    chk("inv6_e3", mem[3][88], 0);
    chk("inv6_e4", mem[4][88], 1);
    chk("inv6_wes", wes, 1);

    // Illegal inv_op and illegal op
    do_req(3'd4, 5'd7, 10'h5, 19'h12DFF, 4'd0, '0, lat, wes, widx);
    chk("inv7_lat", lat, 2);
    chk("inv7_err", resp_err, 1);
    chk("inv7_wes", wes, 0);
    chk("inv7_e4", mem[4][88], 1);
    do_req(3'd5, 5'd0, 10'h0, 19'h0, 4'd0, 89'h1, lat, wes, widx);
    chk("op5_err", resp_err, 1);
    chk("op5_wes", wes, 0);
    do_req(3'd1, 5'd0, 10'h0, 19'h0, 4'd4, '0, lat, wes, widx);
    chk("rd_after_err", resp_err, 0);

    // Reset during an INV op 0 scan at scan_idx 8
    for (int i = 0; i < TLBNUM; i++)
      preload(4'(i), mk_ent(1'b1, 19'(i), 6'd12, 10'h1, 1'b0, 20'(i)));
    chk("abort_ready_pre", req_ready, 1);
    req_op = 3'd4; req_inv_op = 5'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_ready", req_ready, 1);
    chk("abort_we", tlb_we, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_resp", cnt, 0);
    for (int i = 0; i < TLBNUM; i++)
      chk($sformatf("abort_e%0d", i), mem[i][88], (i < 8) ? 89'd0 : 89'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_maint_ctrl.md
# tlb_maint_ctrl

Multi-cycle sequencer for TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) between the CSR/EXE stage and the 16-entry TLB array. It accepts one request at a time over a valid/ready handshake and drives the TLB's dedicated search, read and write ports. INVTLB runs as a per-entry scan, one entry per cycle. Fill-index selection is also done here.

## Interface
- TLBNUM, 16, number of TLB entries (power of two)
- IDXW, $clog2(TLBNUM), index width
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when valid&&ready
- req_op  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 illegal
- req_inv_op  in  5  INVTLB op code (0-6 legal)
- req_asid  in  10  ASID for SRCH/INV
- req_vppn  in  19  VPPN for SRCH/INV
- req_index  in  IDXW  entry index for RD/WR
- req_entry  in  89  entry for WR/FILL, packed msb→lsb: e, vppn[19], ps[6], asid[10], g, ppn0[20], plv0[2], mat0[2], d0, v0, ppn1[20], plv1[2], mat1[2], d1, v1
- resp_valid  out  1  one-cycle completion pulse
- resp_found  out  1  SRCH hit
- resp_index  out  IDXW  SRCH hit index / FILL index used
- resp_entry  out  89  RD data (same packing)
- resp_err  out  1  illegal req_op or req_inv_op
- tlb_s_vppn, tlb_s_asid  out  19, 10  to TLB search port
- tlb_s_found, tlb_s_index  in  1, IDXW  from TLB search port
- tlb_r_index  out  IDXW  TLB read index
- tlb_r_entry  in  89  TLB read data (combinational)
- tlb_we, tlb_w_index, tlb_w_entry  out  1, IDXW, 89  TLB write port

## Operation
- States: IDLE, EXEC, SCAN, DONE. req_ready = (state==IDLE).
- On accept, latch op, inv_op, asid, vppn, index, entry. Go to SCAN if op==INV and inv_op≤6. Otherwise go to EXEC.
- EXEC drives the TLB for exactly one cycle, then goes to DONE.
  - SRCH: drive tlb_s_* from latched values; capture found/index.
  - RD: tlb_r_index = latched index; capture tlb_r_entry.
  - WR: tlb_we=1, w_index = latched index, w_entry = latched entry.
  - FILL: as WR but w_index = fill_ptr; capture fill_ptr into resp_index; fill_ptr increments mod TLBNUM.
  - Illegal op or inv_op: no TLB access; resp_err=1.
- SCAN: scan_idx runs 0..TLBNUM-1, one per cycle, with tlb_r_index = scan_idx.
  - Match on the read entry, where vm = vppn compare on [18:10] if ps==22, else [18:0]:
    - ops 0/1: any
    - op 2: g=1
    - op 3: g=0
    - op 4: g=0 && asid equal
    - op 5: g=0 && asid equal && vm
    - op 6: (g || asid equal) && vm
  - If match && e=1: tlb_we=1 in the same cycle, w_index = scan_idx, w_entry = tlb_r_entry with e cleared.
  - After index TLBNUM-1, go to DONE.
- DONE: resp_valid=1 for one cycle, then IDLE. resp_* hold their values until the next DONE.
- tlb_we/w_* are combinational from state and tlb_r_entry. They are 0 outside EXEC-WR/FILL and SCAN-match.

## Timing
- Accept at edge T. EXEC or first SCAN cycle is T+1. DONE (resp_valid) is T+2 for non-INV, T+TLBNUM+1 for INV. The next accept is at T+3 at the earliest.
- WR/FILL write lands at edge T+2; an RD accepted at T+3 returns the new data.
- Reset asserted at any time: state IDLE, fill_ptr=0, scan_idx=0, resp_valid/found/err=0, resp_index=0, resp_entry=0, tlb_we=0. req_ready=1 while and after reset. An INV scan aborted by reset keeps the invalidations already written.
- req_valid while busy is ignored; the request must be held until ready.
- fill_ptr wraps TLBNUM-1→0.

## Test plan
- WR index 5 with vppn=0x12345, asid=0x3, e=1, then RD index 5 → resp_valid at T+2, resp_entry equals the written 89-bit value.
- SRCH vppn=0x12345, asid=0x3 against entry 5 → resp_found=1, resp_index=5. SRCH asid=0x4 with g=0 → resp_found=0.
- Four FILLs after reset → resp_index 0,1,2,3, tlb_w_index matches each. After 16 FILLs the pointer wraps to 0.
- Entries 2 (g=1), 7 (g=0, asid 3), 9 (g=0, asid 4); INV op 4 asid 3 → only entry 7 cleared, resp_valid at T+17, exactly one tlb_we pulse.
- INV op 6 with 4MB entry vppn 0x12C00, lookup vppn 0x12DFF → cleared. INV op 7 → resp_err=1 at T+2, no tlb_we.
- Reset asserted at scan_idx 8 of INV op 0 → entries 0-7 cleared, 8-15 intact, req_ready=1, resp_valid never pulses.
